// File: rtl/gate_sweep_controller.sv
`timescale 1ns/1ps
// gate_sweep_controller
// Built-in self-test sequencer for the gate F = !C && (!A || B). On START it
// walks {A,B,C} through all 8 vectors. For each vector it waits SETTLE_CYCLES+1
// cycles and then samples F_IN into RESULT. Once the sweep ends it compares
// RESULT against EXPECTED.
//
// Ports:
//   CLK, RST      clock; asynchronous active-high reset
//   START         request a sweep (accepted only in IDLE, ABORT low)
//   ABORT         cancel a sweep in progress (no DONE pulse)
//   F_IN          gate output under test
//   A, B, C       gate inputs, {A,B,C} = current vector index
//   BUSY          sweep running
//   DONE          one-cycle completion pulse
//   PASS          last completed sweep matched EXPECTED
//   RESULT        captured F per vector index
//   MISMATCH      RESULT ^ EXPECTED
//   FIRST_FAIL    lowest mismatching index, 0 when none
//
// Optional build macro GATE_SWEEP_STOP_ON_FAIL_EN: a sweep ends at the first
// vector whose sample disagrees with EXPECTED.
module gate_sweep_controller #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter logic [7:0]  EXPECTED      = 8'h45
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic       ABORT,
   input  logic       F_IN,
   output logic       A,
   output logic       B,
   output logic       C,
   output logic       BUSY,
   output logic       DONE,
   output logic       PASS,
   output logic [7:0] RESULT,
   output logic [7:0] MISMATCH,
   output logic [2:0] FIRST_FAIL
);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, FINISH} state_t;

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

   state_t     state, state_nxt;
   logic [2:0] idx, idx_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       busy_nxt, done_nxt, pass_nxt;
   logic [7:0] result_nxt, mismatch_nxt, final_mismatch, visited;
   logic [2:0] first_fail_nxt, final_first;
   logic       stop;

   // The gate inputs are the index register bits directly, so they are registered.
   assign A = idx[2];
   assign B = idx[1];
   assign C = idx[0];

`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
   assign stop    = (F_IN != EXPECTED[idx]);
   // idx stays on the last visited vector, so bits 0..idx are the tested ones
   assign visited = 8'hFF >> (3'd7 - idx);
`else
   assign stop    = 1'b0;
   assign visited = 8'hFF;
`endif

   assign final_mismatch = (RESULT ^ EXPECTED) & visited;

   always_comb begin
      final_first = '0;
      for (int unsigned i = 8; i > 0; i--) begin
         if (final_mismatch[i-1]) final_first = 3'(i - 1);
      end
   end

   always_comb begin
      state_nxt      = state;
      idx_nxt        = idx;
      cnt_nxt        = cnt;
      busy_nxt       = BUSY;
      done_nxt       = 1'b0;
      pass_nxt       = PASS;
      result_nxt     = RESULT;
      mismatch_nxt   = MISMATCH;
      first_fail_nxt = FIRST_FAIL;
      unique case (state)
         IDLE: begin
            if (START && !ABORT) begin
               idx_nxt        = '0;
               result_nxt     = '0;
               mismatch_nxt   = '0;
               pass_nxt       = 1'b0;
               first_fail_nxt = '0;
               cnt_nxt        = SETTLE_LOAD;
               busy_nxt       = 1'b1;
               state_nxt      = SETTLE;
            end
         end
         SETTLE: begin
            if (ABORT) begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
               pass_nxt  = 1'b0;
               idx_nxt   = '0;
               cnt_nxt   = '0;
            end else if (cnt == '0) begin
               state_nxt = SAMPLE;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         SAMPLE: begin
            if (ABORT) begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
               pass_nxt  = 1'b0;
               idx_nxt   = '0;
               cnt_nxt   = '0;
            end else begin
               result_nxt[idx] = F_IN;
               // BUSY drops on entry to FINISH so it reads low during FINISH
               if (idx == 3'd7 || stop) begin
                  state_nxt = FINISH;
                  busy_nxt  = 1'b0;
               end else begin
                  idx_nxt   = idx + 3'd1;
                  cnt_nxt   = SETTLE_LOAD;
                  state_nxt = SETTLE;
               end
            end
         end
         FINISH: begin
            done_nxt       = 1'b1;
            mismatch_nxt   = final_mismatch;
            pass_nxt       = (final_mismatch == '0);
            first_fail_nxt = final_first;
            state_nxt      = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= IDLE;
         idx        <= '0;
         cnt        <= '0;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
         PASS       <= 1'b0;
         RESULT     <= '0;
         MISMATCH   <= '0;
         FIRST_FAIL <= '0;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         cnt        <= cnt_nxt;
         BUSY       <= busy_nxt;
         DONE       <= done_nxt;
         PASS       <= pass_nxt;
         RESULT     <= result_nxt;
         MISMATCH   <= mismatch_nxt;
         FIRST_FAIL <= first_fail_nxt;
      end
   end

endmodule

// File: tb/tb_gate_sweep_controller.sv
`timescale 1ns/1ps
// Bench for gate_sweep_controller: dut0 uses default settle time, dut1 uses
// SETTLE_CYCLES = 0. Each DUT's F_IN comes from a gate model whose truth
// table can be corrupted by a per-vector fault mask.
module tb_gate_sweep_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start0 = 1'b0, abort0 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
   logic [7:0] mask0 = '0, mask1 = '0;
   logic       f0, f1;
   logic       a0, b0, c0, busy0, done0, pass0;
   logic       a1, b1, c1, busy1, done1, pass1;
   logic [7:0] result0, mism0, result1, mism1;
   logic [2:0] ff0, ff1;

   int tests = 0;
   int fails = 0;

   logic       sel_r = 1'b0;
   logic       busy_s, done_s, pass_s;
   logic [2:0] abc_s, ff_s;
   logic [7:0] result_s, mism_s;

   logic [7:0] last_er, last_em;
   logic       last_ep;
   logic [2:0] last_ef;

   always #5 clk = ~clk;

   function automatic logic gate_f(input logic [2:0] v);
      return !v[0] && (!v[2] || v[1]);
   endfunction

   assign f0 = gate_f({a0, b0, c0}) ^ mask0[{a0, b0, c0}];
   assign f1 = gate_f({a1, b1, c1}) ^ mask1[{a1, b1, c1}];

   assign busy_s   = sel_r ? busy1 : busy0;
   assign done_s   = sel_r ? done1 : done0;
   assign pass_s   = sel_r ? pass1 : pass0;
   assign abc_s    = sel_r ? {a1, b1, c1} : {a0, b0, c0};
   assign ff_s     = sel_r ? ff1 : ff0;
   assign result_s = sel_r ? result1 : result0;
   assign mism_s   = sel_r ? mism1 : mism0;

   gate_sweep_controller #(.SETTLE_CYCLES(2), .EXPECTED(8'h45)) dut0 (
      .CLK(clk), .RST(rst), .START(start0), .ABORT(abort0), .F_IN(f0),
      .A(a0), .B(b0), .C(c0), .BUSY(busy0), .DONE(done0), .PASS(pass0),
      .RESULT(result0), .MISMATCH(mism0), .FIRST_FAIL(ff0)
   );

   gate_sweep_controller #(.SETTLE_CYCLES(0), .EXPECTED(8'h45)) dut1 (
      .CLK(clk), .RST(rst), .START(start1), .ABORT(abort1), .F_IN(f1),
      .A(a1), .B(b1), .C(c1), .BUSY(busy1), .DONE(done1), .PASS(pass1),
      .RESULT(result1), .MISMATCH(mism1), .FIRST_FAIL(ff1)
   );

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   function automatic logic [7:0] truth_table();
      logic [7:0] t;
      for (int i = 0; i < 8; i++) t[i] = gate_f(3'(i));
      return t;
   endfunction

   function automatic int lowest(input logic [7:0] m);
      int r = 0;
      for (int i = 7; i >= 0; i--) if (m[i]) r = i;
      return r;
   endfunction

   // Expected outcome of one sweep with settle time s and fault mask applied
   task automatic model(input logic [7:0] mask, input int s,
                        output logic [7:0] er, output logic [7:0] em, output logic ep,
                        output logic [2:0] ef, output logic [2:0] eabc, output int lat);
      logic [7:0] cap;
      cap  = truth_table() ^ mask;
      er   = cap;
      em   = mask;
      eabc = 3'd7;
      lat  = 8 * (s + 2) + 1;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
      if (mask != 0) begin
         int k;
         k    = lowest(mask);
         er   = cap & 8'((2 << k) - 1);
         em   = 8'(1 << k);
         eabc = 3'(k);
         lat  = (k + 1) * (s + 2) + 1;
      end
`endif
      ef = 3'(lowest(em));
      ep = (em == 0);
   endtask

   task automatic set_start(input bit sel, input logic v);
      if (sel) start1 = v; else start0 = v;
   endtask

   // poke >= 0 pulses START again that many cycles into the sweep
   task automatic run_sweep(input bit sel, input logic [7:0] mask, input int poke, input string tag);
      int s, cyc, busy_cnt, extra_done, extra_busy, lat;
      logic [7:0] er, em;
      logic ep;
      logic [2:0] ef, eabc;
      s = sel ? 0 : 2;
      sel_r = sel;
      if (sel) mask1 = mask; else mask0 = mask;
      model(mask, s, er, em, ep, ef, eabc, lat);
      @(negedge clk);
      set_start(sel, 1'b1);
      @(negedge clk);
      set_start(sel, 1'b0);
      cyc = 0;
      busy_cnt = 0;
      while (!done_s && cyc < 400) begin
         if (busy_s) busy_cnt++;
         set_start(sel, cyc == poke);
         @(negedge clk);
         cyc++;
      end
      set_start(sel, 1'b0);
      check({tag, "_latency"}, cyc, lat);
      check({tag, "_busy_cycles"}, busy_cnt, lat - 1);
      check({tag, "_result"}, result_s, er);
      check({tag, "_mismatch"}, mism_s, em);
      check({tag, "_pass"}, pass_s, ep);
      check({tag, "_first_fail"}, ff_s, ef);
      check({tag, "_abc"}, abc_s, eabc);
      extra_done = 0;
      extra_busy = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done_s) extra_done++;
         if (busy_s) extra_busy++;
      end
      check({tag, "_done_once"}, extra_done, 0);
      check({tag, "_idle_after"}, extra_busy, 0);
      last_er = er;
      last_em = em;
      last_ep = ep;
      last_ef = ef;
   endtask

   initial begin
      int n;
      logic [7:0] m;

      // Reset state
      #2;
      check("rst_busy0", busy0, 0);
      check("rst_outs0", {a0, b0, c0, done0, pass0, result0, mism0, ff0}, 0);
      check("rst_outs1", {a1, b1, c1, busy1, done1, pass1, result1, mism1, ff1}, 0);
      @(negedge clk);
      rst = 1'b0;

      // Correct gate, then F stuck at 1 (every 0 in the truth table flips)
      run_sweep(0, 8'h00, -1, "good");
      run_sweep(0, 8'hBA, -1, "stuck1");

      // Abort 10 cycles after START
      sel_r = 0;
      mask0 = 8'h00;
      @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (9) @(negedge clk);
      abort0 = 1'b1;
      @(negedge clk);
      abort0 = 1'b0;
      check("abort_busy", busy0, 0);
      check("abort_done", done0, 0);
      check("abort_abc", {a0, b0, c0}, 0);
      check("abort_pass", pass0, 0);
      check("abort_partial", result0, truth_table() & 8'h03);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done0 || busy0) n++;
      end
      check("abort_quiet", n, 0);
      run_sweep(0, 8'h00, -1, "post_abort");

      // Asynchronous reset during settle of vector 4
      @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (17) @(negedge clk);
      check("pre_rst_abc", {a0, b0, c0}, 3'd4);
      #1 rst = 1'b1;
      #1;
      check("async_rst_outs", {a0, b0, c0, busy0, done0, pass0, result0, mism0, ff0}, 0);
      @(negedge clk);
      rst = 1'b0;
      run_sweep(0, 8'h00, -1, "post_rst");

      // Zero settle time, with a second START while busy
      run_sweep(1, 8'h00, 5, "settle0");
      run_sweep(1, 8'hBA, 3, "settle0_stuck");

      // Randomized fault masks
      for (int i = 0; i < 6; i++) begin
         m = 8'($urandom_range(0, 255));
         if (i == 0) m = 8'(1 << $urandom_range(0, 7));
         run_sweep(i % 2 == 1, m, -1, $sformatf("rand%0d", i));
      end

      // START and ABORT together in IDLE: no sweep, results held
      sel_r = 0;
      run_sweep(0, 8'h24, -1, "pre_hold");
      @(negedge clk);
      start0 = 1'b1;
      abort0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      abort0 = 1'b0;
      n = 0;
      for (int i = 0; i < 5; i++) begin
         if (busy0) n++;
         @(negedge clk);
      end
      check("startabort_busy", n, 0);
      check("hold_result", result0, last_er);
      check("hold_mismatch", mism0, last_em);
      check("hold_pass", pass0, last_ep);
      check("hold_first_fail", ff0, last_ef);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
